i2s_tx_serializer: RTL and testbench
====================================

# i2s_tx_serializer

Serializer stage directly downstream of the audio filter top. It accepts one 32-bit DAC word per audio frame through a valid/ready handshake and buffers it in a single holding register. It drives a standard Philips I2S stream (BCLK, LRCLK, SDATA) to the external DAC codec, transmitting the word's signed 24-bit sample (bits [23:0]) MSB-first on both left and right channels (mono duplication).

## Interface
- `BCLK_DIV`, 4, system clocks per BCLK half-period; minimum 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dac_data`  in  32  DAC word; bits [23:0] are the signed sample, bits [31:24] are ignored.
- `dac_valid`  in  1  `dac_data` is valid this cycle.
- `dac_ready`  out  1  holding register is empty; equals `!hold_full` (combinational from a register).
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  I2S word select; 0 = left, 1 = right.
- `sdata`  out  1  I2S serial data.
- `frame_start`  out  1  one-cycle pulse when slot position 0 begins.
- `underrun`  out  1  one-cycle pulse, coincident with `frame_start`, when no new sample was available.

## Operation
- **Divider:** `div_cnt` counts 0..BCLK_DIV-1. At terminal count it wraps and `bclk` toggles.
- **Bit counter:** `bit_cnt` is 6 bits and holds slot position p = 0..63. It advances only on a BCLK falling toggle (1→0) and wraps 63→0.
- **Word select:** on the falling toggle entering p=0, `lrclk` ← 0. Entering p=32, `lrclk` ← 1.
- **Data:** with k = p mod 32, `sdata` = shadow[24-k] for k in 1..24, and 0 for k = 0 or 25..31.
  - This gives the one-BCLK MSB delay required by I2S.
  - All outputs update in the same clk cycle as the falling toggle, so data is stable at the BCLK rising edge.
- **Handshake:** a transfer occurs when `dac_valid && dac_ready`. `dac_data[23:0]` is written to `hold`, and `hold_full` is set.
- **Frame load:** on the falling toggle entering p=0, `frame_start` pulses.
  - If `hold_full` is set (registered value): shadow ← hold and `hold_full` is cleared.
  - Otherwise: shadow is unchanged (the last sample is repeated) and `underrun` pulses.
- **Simultaneous accept and frame load:** the frame load uses the pre-edge `hold_full`. No bypass is applied. If `hold_full` was 0, `underrun` pulses and the newly accepted sample is loaded at the next frame.
- **dac_data while not ready:** `dac_data` is ignored whenever `dac_ready` = 0.
- **Reset mid-frame:** all state is forced immediately to reset values and any partial frame is abandoned.

## Timing
- **Reset values:**
  - Outputs: `bclk` = 0, `lrclk` = 1, `sdata` = 0, `dac_ready` = 1, `frame_start` = 0, `underrun` = 0.
  - Internal state: `div_cnt` = 0, `bit_cnt` = 63, shadow = 0, `hold_full` = 0.
- **BCLK and frame rate:** BCLK period is 2·BCLK_DIV clk cycles. A frame is 64 BCLK periods, i.e. 128·BCLK_DIV clk cycles.
- **First frame after reset release:**
  - The first rising toggle occurs at clk edge BCLK_DIV.
  - The first falling toggle occurs at clk edge 2·BCLK_DIV; it enters p=0 with `lrclk` = 0.
  - If nothing was accepted before this edge, `underrun` pulses.
- **Latency:** from a transfer to the MSB on `sdata`, it is the time to the next p=0 entry plus one BCLK period (MSB at p=1). The right-channel MSB appears at p=33.
- **Rate limit:** at most one sample is consumed per frame. `dac_ready` deasserts for the remainder of the frame once the holding register is filled.

## Configuration
- **`I2S_TX_UNDERRUN_CNT_EN` defined:**
  - Adds output port `underrun_count` (out, 16 bits), reset to 0.
  - Increments on each `underrun` pulse and saturates at 16'hFFFF (no wrap).
- **Not defined:** the port and counter are absent, and the `underrun` pulse behaves the same.

## Test plan
- **Reset:** hold `reset` = 0 for 5 cycles, then release → all outputs match their reset values, and the first falling toggle and `frame_start` occur exactly 8 clk cycles after release (BCLK_DIV = 4).
- **Single sample:** present 32'h00A5_5A5A with `dac_valid` = 1 before the first frame → left and right slots each shift out A55A5A MSB-first at p=1..24 and p=33..56, padding bits are 0, and `underrun` never pulses.
- **Backpressure:** keep `dac_valid` = 1 with incrementing data → exactly one transfer per 512 clk cycles, and each frame carries the next value with none skipped.
- **Underrun:** send 24'h800000, then stop → following frames repeat 800000 with an `underrun` pulse each frame; with the macro defined, `underrun_count` reaches 3 after 3 starved frames.
- **Collision:** assert a single-cycle valid in the exact cycle p=0 is entered, with hold empty → `underrun` = 1 that frame, and the sample appears in the next frame.
- **Reset mid-frame:** assert `reset` at p=40 → `sdata` = 0 and `lrclk` = 1 immediately, `hold_full` is cleared, and a clean restart follows the release.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: one 24-bit sample per frame, duplicated on left and right.
// Optional underrun counter port is enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_serializer #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dac_data,
    input  logic        dac_valid,
    output logic        dac_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_start,
    output logic        underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             frame_start_q, frame_start_d;
    logic             underrun_q, underrun_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [23:0]      hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic             div_tc;
    logic             bclk_fall;
    logic [4:0]       slot_k;
    logic [4:0]       sdata_idx;

    // Upper DAC word bits carry no audio.
    logic [7:0]       unused_dac_hi;
    assign unused_dac_hi = dac_data[31:24];

    always_comb begin
        div_cnt_d     = div_cnt_q + 1'b1;
        bit_cnt_d     = bit_cnt_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        shadow_d      = shadow_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        slot_k        = 5'd0;
        sdata_idx     = 5'd0;

        div_tc = (div_cnt_q == DIV_LAST);
        if (div_tc) begin
            div_cnt_d = '0;
            bclk_d    = !bclk_q;
        end
        bclk_fall = div_tc && bclk_q;

        if (bclk_fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_d == 6'd0) begin
                lrclk_d       = 1'b0;
                frame_start_d = 1'b1;
                // Frame load sees the pre-edge hold flag; a sample accepted
                // on this same edge waits for the next frame.
                if (hold_full_q) begin
                    shadow_d    = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    underrun_d  = 1'b1;
                end
            end else if (bit_cnt_d == 6'd32) begin
                lrclk_d = 1'b1;
            end

            // Slot bit k carries sample bit 24-k, giving the one-BCLK MSB delay.
            slot_k    = bit_cnt_d[4:0];
            sdata_idx = 5'd24 - slot_k;
            if (slot_k >= 5'd1 && slot_k <= 5'd24) begin
                sdata_d = shadow_q[sdata_idx];
            end else begin
                sdata_d = 1'b0;
            end
        end

        if (dac_valid && !hold_full_q) begin
            hold_d      = dac_data[23:0];
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= 6'd63;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            shadow_q      <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            shadow_q      <= shadow_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count_q, underrun_count_d;

    // Saturating so a long starvation never wraps back to a small count.
    always_comb begin
        underrun_count_d = underrun_count_q;
        if (underrun_d && underrun_count_q != 16'hFFFF) begin
            underrun_count_d = underrun_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_count_q <= 16'd0;
        end else begin
            underrun_count_q <= underrun_count_d;
        end
    end

    assign underrun_count = underrun_count_q;
`endif

    assign dac_ready   = !hold_full_q;
    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomized bench for i2s_tx_serializer against a frame-level timing model.
// Define I2S_TX_UNDERRUN_CNT_EN to also check the underrun counter port.
module tb_i2s_tx_serializer;

    localparam int DIV   = 4;
    localparam int FRAME = 128 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dac_data = 32'd0;
    logic        dac_valid = 1'b0;
    logic        dac_ready, bclk, lrclk, sdata, frame_start, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    i2s_tx_serializer #(.BCLK_DIV(DIV)) dut (
        .clk(clk),
        .reset(rst_n),
        .dac_data(dac_data),
        .dac_valid(dac_valid),
        .dac_ready(dac_ready),
        .bclk(bclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .frame_start(frame_start),
        .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: edges since reset release plus the sample buffers.
    int          n;
    logic        m_full;
    logic [23:0] m_hold, m_shadow;
    logic        m_fs, m_ur;
    int          m_ucnt;
    logic [23:0] lcap, rcap;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int pos(input int nn);
        return ((nn / (2 * DIV)) + 63) % 64;
    endfunction

    function automatic bit is_entry(input int nn);
        return (nn > 0) && (nn % (2 * DIV) == 0) && ((nn / (2 * DIV)) % 64 == 1);
    endfunction

    task automatic model_reset();
        n = 0; m_full = 1'b0; m_hold = '0; m_shadow = '0;
        m_fs = 1'b0; m_ur = 1'b0; m_ucnt = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d);
        logic acc;
        n++;
        acc  = v && !m_full;
        m_fs = is_entry(n);
        m_ur = m_fs && !m_full;
        if (m_fs && m_full) begin
            m_shadow = m_hold;
            m_full   = 1'b0;
        end
        if (acc) begin
            m_hold = d[23:0];
            m_full = 1'b1;
        end
        if (m_ur && m_ucnt < 65535) m_ucnt++;
    endtask

    function automatic logic [5:0] exp_vec();
        int p, k;
        logic b, lr, sd;
        p  = pos(n);
        k  = p % 32;
        b  = ((n / DIV) % 2) == 1;
        lr = (p >= 32);
        sd = (k >= 1 && k <= 24) ? m_shadow[24 - k] : 1'b0;
        return {!m_full, b, lr, sd, m_fs, m_ur};
    endfunction

    task automatic check_outputs(input string tag);
        check_val(tag, {26'd0, dac_ready, bclk, lrclk, sdata, frame_start, underrun},
                  {26'd0, exp_vec()});
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check_val({tag, "_ucnt"}, {16'd0, underrun_count}, 32'(m_ucnt));
`endif
    endtask

    task automatic step(input string tag);
        int p;
        @(posedge clk);
        if (rst_n) model_edge(dac_valid, dac_data);
        else       model_reset();
        #1;
        check_outputs(tag);
        if (rst_n && n % (2 * DIV) == 0) begin
            p = pos(n);
            if (p >= 1 && p <= 24)  lcap = {lcap[22:0], sdata};
            if (p >= 33 && p <= 56) rcap = {rcap[22:0], sdata};
        end
    endtask

    initial begin
        int first_fs, xfers, fs, ur, cnt;
        logic hs;
        logic [31:0] coll_data;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        logic [15:0] ucnt0;
`endif
        lcap = '0; rcap = '0;
        model_reset();

        // Reset held for 5 cycles.
        repeat (5) step("reset");
        rst_n = 1'b1;

        // Single sample before the first frame; first frame_start 8 cycles after release.
        dac_valid = 1'b1;
        dac_data  = 32'h00A5_5A5A;
        first_fs  = -1;
        step("single");
        dac_valid = 1'b0;
        for (int i = 2; i <= 20; i++) begin
            step("single");
            if (frame_start && first_fs < 0) first_fs = i;
        end
        check_val("first_fs", 32'(first_fs), 32'd8);
        while (n < FRAME + 8) step("single");
        check_val("single_left", {8'd0, lcap}, 32'h00A5_5A5A);
        check_val("single_right", {8'd0, rcap}, 32'h00A5_5A5A);

        // Align to a frame entry, then hold valid high with incrementing data.
        for (int i = 0; i < FRAME + 2 && !m_fs; i++) step("align");
        check_val("align_fs", {31'd0, m_fs}, 32'd1);
        cnt = 1;
        xfers = 0;
        dac_valid = 1'b1;
        dac_data  = {8'($urandom), 24'(cnt)};
        for (int i = 0; i < 3 * FRAME; i++) begin
            hs = dac_valid && dac_ready;
            step("bp");
            if (hs) begin
                xfers++;
                cnt++;
                dac_data = {8'($urandom), 24'(cnt)};
            end
        end
        dac_valid = 1'b0;
        check_val("bp_xfers", 32'(xfers), 32'd3);

        // Send 800000 once, then starve.
        dac_valid = 1'b1;
        dac_data  = 32'h5580_0000;
        hs = 1'b0;
        for (int i = 0; i < FRAME + 2 && !hs; i++) begin
            hs = dac_valid && dac_ready;
            step("ur_send");
        end
        check_val("ur_send_hs", {31'd0, hs}, 32'd1);
        dac_valid = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ucnt0 = underrun_count;
`endif
        fs = 0; ur = 0;
        for (int i = 0; i < 5 * FRAME && fs < 4; i++) begin
            step("ur");
            if (frame_start) begin
                fs++;
                if (underrun) ur++;
            end
        end
        check_val("ur_frames", 32'(fs), 32'd4);
        check_val("ur_pulses", 32'(ur), 32'd3);
        check_val("ur_left", {8'd0, lcap}, 32'h0080_0000);
        check_val("ur_right", {8'd0, rcap}, 32'h0080_0000);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check_val("ur_count_delta", {16'd0, underrun_count - ucnt0}, 32'd3);
`endif

        // Collision: one-cycle valid on the very edge that enters p=0 with hold empty.
        for (int i = 0; i < FRAME + 2 && !(is_entry(n + 1) && !m_full); i++) step("coll_wait");
        coll_data = $urandom;
        dac_valid = 1'b1;
        dac_data  = coll_data;
        step("coll");
        dac_valid = 1'b0;
        check_val("coll_ur", {31'd0, underrun}, 32'd1);
        check_val("coll_taken", {31'd0, dac_ready}, 32'd0);
        fs = 0;
        for (int i = 0; i < FRAME + 2 && fs == 0; i++) begin
            step("coll_next");
            if (frame_start) fs++;
        end
        check_val("coll_next_ur", {31'd0, underrun}, 32'd0);
        repeat (26 * 2 * DIV) step("coll_next");
        check_val("coll_left", {8'd0, lcap}, {8'd0, coll_data[23:0]});

        // Random traffic.
        repeat (4 * FRAME) begin
            dac_valid = ($urandom % 4) == 0;
            dac_data  = $urandom;
            step("rand");
        end
        dac_valid = 1'b0;

        // Reset asserted mid-frame at p=40.
        for (int i = 0; i < 2 * FRAME && pos(n) != 40; i++) step("rst_wait");
        check_val("rst_at_p40", 32'(pos(n)), 32'd40);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid");
        check_val("rst_mid_sdata", {31'd0, sdata}, 32'd0);
        check_val("rst_mid_lrclk", {31'd0, lrclk}, 32'd1);
        check_val("rst_mid_ready", {31'd0, dac_ready}, 32'd1);
        repeat (3) step("rst_hold");
        rst_n = 1'b1;
        first_fs = -1;
        for (int i = 1; i <= 20; i++) begin
            step("restart");
            if (frame_start && first_fs < 0) first_fs = i;
        end
        check_val("restart_fs", 32'(first_fs), 32'd8);
        repeat (FRAME) step("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
